avst_capture_mux_rr: RTL and testbench
======================================

Name: avst_capture_mux_rr

Overview:
- Parametrised N-input, packet-atomic Avalon-ST multiplexer for the video monitor capture path.
- Arbitrates among NUM_IN streams with round-robin or fixed-priority selection.
- Locks the grant for a whole packet, from the first accepted beat to the accepted endofpacket beat.
- Tags each output beat with its source channel and drives a 2-entry skid buffer, giving full throughput with a registered output.

Parameters:
- NUM_IN, 4, number of input streams (2..16).
- DATA_W, 32, data width per beat.
- EMPTY_W, 2, empty field width (0 not allowed; tie off if unused).
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- CH_W, 2, out_channel width; must equal max(1, clog2(NUM_IN)), checked by elaboration assertion.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  NUM_IN  per-input valid.
- in_ready  out  NUM_IN  per-input ready.
- in_data  in  NUM_IN*DATA_W  flattened data; input i occupies [i*DATA_W +: DATA_W].
- in_startofpacket  in  NUM_IN  per-input sop.
- in_endofpacket  in  NUM_IN  per-input eop.
- in_empty  in  NUM_IN*EMPTY_W  flattened empty.
- out_valid  out  1  output valid.
- out_ready  in  1  output ready.
- out_data  out  DATA_W  output data.
- out_startofpacket  out  1  output sop.
- out_endofpacket  out  1  output eop.
- out_empty  out  EMPTY_W  output empty.
- out_channel  out  CH_W  index of the source input for this beat.

Behaviour:
- Clock and reset: single clock clk. reset_n is asynchronous assert, active-low; logic uses synchronous release.
- Reset values:
  - State is IDLE.
  - grant = 0.
  - Round-robin last pointer = NUM_IN-1, so input 0 is first.
  - out_valid = 0; out_data, out_empty, out_sop, out_eop and out_channel = 0.
  - Skid buffer is empty and in_ready = 0 throughout reset.
- States:
  - IDLE: no packet locked. The arbiter picks a candidate combinationally from in_valid.
    - Round-robin picks the first valid index after last, wrapping.
    - Priority picks the lowest valid index.
  - LOCKED: the grant is held. Only in_ready[grant] may be 1.
- Transitions:
  - IDLE -> LOCKED when the candidate beat is accepted (valid and ready) and its eop = 0. grant and last are set to the candidate.
  - IDLE stays IDLE if the accepted beat has eop = 1 (single-beat packet). last still updates.
  - LOCKED -> IDLE on an accepted beat from grant with eop = 1.
- Ready rule: in_ready[i] = (i == active index) & buf_ready. The active index is the candidate in IDLE and grant in LOCKED. All non-selected inputs see ready = 0 (stall, never drop).
- Combinational paths:
  - The in_ready path depends on in_valid in IDLE; no combinational path from out_ready.
  - buf_ready = skid buffer not full, which is registered.
- sop is not used for framing. A locked input whose first beat lacks sop is passed through unchanged; the lock still runs to eop.
- Simultaneous eop accept and a new request in the same cycle: the next grant is decided in the following cycle (one idle cycle between packets is allowed).
  - With round-robin and inputs 0 and 1 continuously valid, packets alternate 0,1,0,1.
- Skid buffer:
  - Two entries, holding {channel, sop, eop, empty, data}.
  - Latency is 1 cycle from input accept to out_valid.
  - Sustains 1 beat/clk when out_ready = 1.
  - Output is held stable while out_valid & !out_ready.
  - buf_ready deasserts only when both entries are full.
- Reset mid-packet: clears the lock and buffered beats immediately; any partial packet is lost. Upstream must tolerate this.
- Empty is passed through unmodified; no width arithmetic.

Decomposition:
- Shared package avst_mux_pkg:
  - function clog2_min1(n).
  - ARB_RR / ARB_PRIO constants.
  - State encoding IDLE/LOCKED.
- Sub-module avst_skid_buffer_2 (parameter WIDTH): the 2-entry registered-ready pipeline stage, reusable elsewhere.
- Arbiter logic stays inline (about 40 lines).

Test Plan:
- Reset then single input 2 sends a 3-beat packet with data A,B,C -> out beats A(sop),B,C(eop), each with out_channel = 2; first out_valid one cycle after the first accept.
- Round-robin: inputs 0 and 3 always valid with 2-beat packets -> output channel sequence 0,0,3,3,0,0,3,3; no interleaving inside a packet.
- ARB_MODE = 1: inputs 1 and 2 always valid -> only channel 1 packets appear; in_ready[2] stays 0.
- Backpressure: out_ready = 0 for 5 cycles mid-packet -> at most 2 beats are buffered, in_ready drops, and no beat is lost or duplicated; the data order matches the source.
- Single-beat packets (sop = eop = 1) on inputs 0 and 1 alternately -> the state never leaves IDLE and channels alternate 0,1.
- reset_n asserted mid-packet after beat 2 of 4 -> out_valid = 0 within the same cycle asynchronously, and round-robin restarts from input 0 after release.

Source files
------------

// File: rtl/avst_capture_mux_rr_pkg.sv
// Shared definitions for the packet-atomic Avalon-ST capture multiplexer.
package avst_mux_pkg;

  localparam int ARB_RR   = 0;
  localparam int ARB_PRIO = 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } mux_state_t;

  // Channel index width; a 2-input mux still needs one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < n) r = k + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/avst_capture_mux_rr_if.sv
// Bundle of the N input streams and the tagged output stream of the capture mux.
interface avst_capture_mux_rr_if #(
  parameter int NUM_IN  = 4,
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2,
  parameter int CH_W    = 2
);
  logic [NUM_IN-1:0]         in_valid;
  logic [NUM_IN-1:0]         in_ready;
  logic [NUM_IN*DATA_W-1:0]  in_data;
  logic [NUM_IN-1:0]         in_startofpacket;
  logic [NUM_IN-1:0]         in_endofpacket;
  logic [NUM_IN*EMPTY_W-1:0] in_empty;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic                      out_startofpacket;
  logic                      out_endofpacket;
  logic [EMPTY_W-1:0]        out_empty;
  logic [CH_W-1:0]           out_channel;

  modport slave (
    input  in_valid, in_data, in_startofpacket, in_endofpacket, in_empty, out_ready,
    output in_ready, out_valid, out_data, out_startofpacket, out_endofpacket,
           out_empty, out_channel
  );

  modport master (
    output in_valid, in_data, in_startofpacket, in_endofpacket, in_empty, out_ready,
    input  in_ready, out_valid, out_data, out_startofpacket, out_endofpacket,
           out_empty, out_channel
  );
endinterface

// File: rtl/avst_capture_mux_rr_skid.sv
// Two-entry pipeline stage: registered output and a registered upstream ready.
module avst_skid_buffer_2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic [WIDTH-1:0] head_reg, spare_reg;
  logic             head_valid_reg, spare_valid_reg, ready_reg;
  logic             push, pop, spare_valid_next;

  assign push = in_valid & ready_reg;
  assign pop  = head_valid_reg & out_ready;
  // The spare only fills when the head is occupied and not draining this cycle.
  assign spare_valid_next = spare_valid_reg ? ~pop : (push & head_valid_reg & ~pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_reg        <= '0;
      spare_reg       <= '0;
      head_valid_reg  <= 1'b0;
      spare_valid_reg <= 1'b0;
      ready_reg       <= 1'b0;
    end else begin
      ready_reg       <= ~spare_valid_next;
      spare_valid_reg <= spare_valid_next;
      if (pop) begin
        if (spare_valid_reg) head_reg <= spare_reg;
        else if (push)       head_reg <= in_data;
        else                 head_valid_reg <= 1'b0;
      end else if (push) begin
        if (!head_valid_reg) begin
          head_reg       <= in_data;
          head_valid_reg <= 1'b1;
        end else begin
          spare_reg <= in_data;
        end
      end
    end
  end

  assign in_ready  = ready_reg;
  assign out_valid = head_valid_reg;
  assign out_data  = head_reg;
endmodule

// File: rtl/avst_capture_mux_rr.sv
// Packet-atomic N:1 Avalon-ST mux; each output beat is tagged with its source channel.
module avst_capture_mux_rr
  import avst_mux_pkg::*;
#(
  parameter int NUM_IN   = 4,
  parameter int DATA_W   = 32,
  parameter int EMPTY_W  = 2,
  parameter int ARB_MODE = ARB_RR,
  parameter int CH_W     = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  avst_capture_mux_rr_if.slave bus
);
  localparam int BEAT_W = CH_W + 2 + EMPTY_W + DATA_W;

  generate
    if (CH_W != clog2_min1(NUM_IN)) begin : g_bad_ch_w
      $error("avst_capture_mux_rr: CH_W must equal max(1, clog2(NUM_IN))");
    end
    if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
      $error("avst_capture_mux_rr: NUM_IN must be in 2..16");
    end
    if (EMPTY_W < 1) begin : g_bad_empty_w
      $error("avst_capture_mux_rr: EMPTY_W must be at least 1");
    end
  endgenerate

  mux_state_t         state_reg;
  logic [CH_W-1:0]    grant_reg, last_reg;
  logic [CH_W-1:0]    cand, cand_hi, cand_lo, active;
  logic               hi_found, lo_found, cand_found, sel_ok, buf_ready, accept;
  logic               sel_valid, sel_sop, sel_eop;
  logic [EMPTY_W-1:0] sel_empty;
  logic [DATA_W-1:0]  sel_data;
  logic [BEAT_W-1:0]  beat_in, beat_out;

  // Round-robin: lowest valid index above last, else wrap to lowest valid overall.
  always_comb begin : arbiter
    cand_hi  = '0;
    cand_lo  = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      if (bus.in_valid[k]) begin
        if (ARB_MODE == ARB_PRIO || k <= int'(last_reg)) begin
          cand_lo  = CH_W'(k);
          lo_found = 1'b1;
        end else begin
          cand_hi  = CH_W'(k);
          hi_found = 1'b1;
        end
      end
    end
    cand       = hi_found ? cand_hi : cand_lo;
    cand_found = hi_found | lo_found;
  end

  assign active = (state_reg == LOCKED) ? grant_reg : cand;
  assign sel_ok = (state_reg == LOCKED) | cand_found;

  always_comb begin : beat_select
    sel_valid = 1'b0;
    sel_sop   = 1'b0;
    sel_eop   = 1'b0;
    sel_empty = '0;
    sel_data  = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (active == CH_W'(k)) begin
        sel_valid = bus.in_valid[k];
        sel_sop   = bus.in_startofpacket[k];
        sel_eop   = bus.in_endofpacket[k];
        sel_empty = bus.in_empty[k*EMPTY_W +: EMPTY_W];
        sel_data  = bus.in_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign accept  = sel_ok & sel_valid & buf_ready;
  assign beat_in = {active, sel_sop, sel_eop, sel_empty, sel_data};

  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_ready
      assign bus.in_ready[gi] = sel_ok & buf_ready & (active == CH_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      last_reg  <= CH_W'(NUM_IN - 1);
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            last_reg <= cand;
            if (!sel_eop) begin
              state_reg <= LOCKED;
              grant_reg <= cand;
            end
          end
        end
        LOCKED: begin
          if (accept && sel_eop) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  avst_skid_buffer_2 #(
    .WIDTH(BEAT_W)
  ) u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (accept),
    .in_ready (buf_ready),
    .in_data  (beat_in),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready),
    .out_data (beat_out)
  );

  assign {bus.out_channel, bus.out_startofpacket, bus.out_endofpacket,
          bus.out_empty, bus.out_data} = beat_out;
endmodule

// File: tb/tb_avst_capture_mux_rr.sv
// Randomised scoreboard bench for avst_capture_mux_rr (round-robin and fixed-priority instances).
module tb_avst_capture_mux_rr;
  import avst_mux_pkg::*;

  localparam int NUM_IN  = 4;
  localparam int DATA_W  = 32;
  localparam int EMPTY_W = 2;
  localparam int CH_W    = 2;

  typedef struct packed {
    logic [CH_W-1:0]    ch;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
    logic [DATA_W-1:0]  data;
  } beat_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  avst_capture_mux_rr_if #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .CH_W(CH_W)) bus ();
  avst_capture_mux_rr_if #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .CH_W(CH_W)) bp ();

  avst_capture_mux_rr #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W),
                        .ARB_MODE(ARB_RR), .CH_W(CH_W))
    dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

  avst_capture_mux_rr #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W),
                        .ARB_MODE(ARB_PRIO), .CH_W(CH_W))
    dut_prio (.clk(clk), .reset_n(reset_n), .bus(bp.slave));

  int n_cmp = 0;
  int n_bad = 0;

  beat_t src_q[$];
  beat_t exp_q[$];
  int    seq[$];
  logic [NUM_IN-1:0] cur_valid = '0;
  beat_t cur_beat [NUM_IN];
  int vpct = 100, rpct = 100;
  int stall_lo = -1, stall_hi = -1, phase_cyc = 0;
  int acc_cnt = 0, out_cnt = 0;
  bit acc_now = 1'b0;
  bit mon_en = 1'b0;
  bit in_pkt = 1'b0;
  bit saw_stall = 1'b0;
  int first_acc_cyc = -1, first_out_cyc = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_tb();
    src_q.delete();
    exp_q.delete();
    seq.delete();
    cur_valid = '0;
    bus.in_valid = '0;
    bp.in_valid = '0;
    acc_cnt = 0;
    out_cnt = 0;
    acc_now = 1'b0;
    in_pkt = 1'b0;
    saw_stall = 1'b0;
    first_acc_cyc = -1;
    first_out_cyc = -1;
    stall_lo = -1;
    stall_hi = -1;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    clear_tb();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic add_pkt(input int ch, input int len, input bit with_sop);
    beat_t x;
    for (int b = 0; b < len; b++) begin
      x.ch    = CH_W'(ch);
      x.sop   = (b == 0) && with_sop;
      x.eop   = (b == len - 1);
      x.empty = EMPTY_W'($urandom_range(3));
      x.data  = $urandom;
      src_q.push_back(x);
    end
  endtask

  // One stimulus cycle: present queue heads, then record the handshakes the next edge will take.
  task automatic drive_cycle();
    @(negedge clk);
    for (int i = 0; i < NUM_IN; i++) begin
      if (!cur_valid[i]) begin
        for (int j = 0; j < src_q.size(); j++) begin
          if (src_q[j].ch == CH_W'(i)) begin
            if ($urandom_range(99) < vpct) begin
              cur_valid[i] = 1'b1;
              cur_beat[i]  = src_q[j];
            end
            break;
          end
        end
      end
      bus.in_valid[i]                         = cur_valid[i];
      bus.in_startofpacket[i]                 = cur_beat[i].sop;
      bus.in_endofpacket[i]                   = cur_beat[i].eop;
      bus.in_empty[i*EMPTY_W +: EMPTY_W]      = cur_beat[i].empty;
      bus.in_data[i*DATA_W +: DATA_W]         = cur_beat[i].data;
    end
    if (stall_lo >= 0) bus.out_ready = !(phase_cyc >= stall_lo && phase_cyc < stall_hi);
    else               bus.out_ready = ($urandom_range(99) < rpct);
    phase_cyc++;
    #1;
    acc_now = 1'b0;
    check("ready_onehot", 64'($countones(bus.in_ready) <= 1), 64'd1);
    for (int i = 0; i < NUM_IN; i++) begin
      if (cur_valid[i] && !bus.in_ready[i]) saw_stall = 1'b1;
      if (cur_valid[i] && bus.in_ready[i]) begin
        for (int j = 0; j < src_q.size(); j++) begin
          if (src_q[j].ch == CH_W'(i)) begin
            src_q.delete(j);
            break;
          end
        end
        exp_q.push_back(cur_beat[i]);
        cur_valid[i] = 1'b0;
        acc_cnt++;
        acc_now = 1'b1;
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
      end
    end
  endtask

  task automatic run_phase(input string name, input int max_cycles);
    int n;
    n = 0;
    phase_cyc = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0 || cur_valid != '0) && n < max_cycles) begin
      drive_cycle();
      n++;
    end
    check({name, "_drained"}, 64'(src_q.size() + exp_q.size()), 64'd0);
    @(negedge clk);
    bus.in_valid = '0;
    bus.out_ready = 1'b1;
    acc_now = 1'b0;
  endtask

  // Monitor: compares every transferred output beat against the per-channel expectations.
  initial begin : monitor
    beat_t got, prev;
    bit prev_stall;
    logic [CH_W-1:0] pkt_ch;
    int occ, idx;
    prev_stall = 1'b0;
    pkt_ch = '0;
    prev = '0;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        occ = acc_cnt - int'(acc_now) - out_cnt;
        check("occupancy_le2", 64'(occ <= 2), 64'd1);
        check("out_valid_vs_occupancy", 64'(bus.out_valid), 64'(occ > 0));
        got = {bus.out_channel, bus.out_startofpacket, bus.out_endofpacket,
               bus.out_empty, bus.out_data};
        if (prev_stall) check("hold_stable", {25'd0, bus.out_valid, got}, {25'd0, 1'b1, prev});
        if (bus.out_valid && first_out_cyc < 0) first_out_cyc = cyc;
        if (bus.out_valid && bus.out_ready) begin
          idx = -1;
          for (int j = 0; j < exp_q.size(); j++) begin
            if (exp_q[j].ch == got.ch) begin
              idx = j;
              break;
            end
          end
          n_cmp++;
          if (idx < 0) begin
            n_bad++;
            $display("FAIL unexpected_beat: got %0h with no expected beat on channel %0d", got, got.ch);
          end else begin
            n_cmp--;
            check("beat", 64'(got), 64'(exp_q[idx]));
            exp_q.delete(idx);
          end
          if (in_pkt) check("packet_atomic", 64'(got.ch), 64'(pkt_ch));
          in_pkt = !got.eop;
          pkt_ch = got.ch;
          seq.push_back(int'(got.ch));
          out_cnt++;
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev = got;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    beat_t x;
    int n, b1, acc1;
    bus.in_valid = '0; bus.in_data = '0; bus.in_startofpacket = '0;
    bus.in_endofpacket = '0; bus.in_empty = '0; bus.out_ready = 1'b1;
    bp.in_valid = '0; bp.in_data = '0; bp.in_startofpacket = '0;
    bp.in_endofpacket = '0; bp.in_empty = '0; bp.out_ready = 1'b1;
    for (int i = 0; i < NUM_IN; i++) cur_beat[i] = '0;

    // Reset state
    reset_n = 1'b0;
    bus.in_valid = 4'b1111;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_channel", 64'(bus.out_channel), 64'd0);
    check("rst_prio_in_ready", 64'(bp.in_ready), 64'd0);
    bus.in_valid = '0;

    // Single 3-beat packet on input 2
    do_reset();
    vpct = 100; rpct = 100;
    for (int b = 0; b < 3; b++) begin
      x.ch = 2'd2; x.sop = (b == 0); x.eop = (b == 2); x.empty = 2'(b);
      x.data = 32'hA0A0_0000 + b;
      src_q.push_back(x);
    end
    run_phase("single_pkt", 50);
    check("first_latency", 64'(first_out_cyc - first_acc_cyc), 64'd1);
    check("single_pkt_len", 64'(seq.size()), 64'd3);
    for (int k = 0; k < seq.size(); k++) check("single_pkt_ch", 64'(seq[k]), 64'd2);

    // Round-robin between inputs 0 and 3, 2-beat packets
    do_reset();
    for (int p = 0; p < 4; p++) begin
      add_pkt(0, 2, 1'b1);
      add_pkt(3, 2, 1'b1);
    end
    run_phase("rr_0_3", 200);
    check("rr_len", 64'(seq.size()), 64'd16);
    for (int k = 0; k < seq.size(); k++) check("rr_order", 64'(seq[k]), ((k / 2) % 2 == 0) ? 64'd0 : 64'd3);

    // Single-beat packets alternate between inputs 0 and 1
    do_reset();
    for (int p = 0; p < 6; p++) begin
      add_pkt(0, 1, 1'b1);
      add_pkt(1, 1, 1'b1);
    end
    run_phase("single_beat", 200);
    check("single_beat_len", 64'(seq.size()), 64'd12);
    for (int k = 0; k < seq.size(); k++) check("single_beat_alt", 64'(seq[k]), 64'(k % 2));

    // Output stall for 5 cycles mid-packet
    do_reset();
    add_pkt(1, 10, 1'b1);
    stall_lo = 3; stall_hi = 8;
    run_phase("backpressure", 200);
    check("bp_in_ready_dropped", 64'(saw_stall), 64'd1);
    check("bp_len", 64'(seq.size()), 64'd10);

    // Asynchronous reset after beat 2 of 4, then round-robin restarts at input 0
    do_reset();
    add_pkt(0, 4, 1'b1);
    n = 0;
    phase_cyc = 0;
    while (acc_cnt < 2 && n < 20) begin
      drive_cycle();
      n++;
    end
    check("midrst_two_accepted", 64'(acc_cnt), 64'd2);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid_async", 64'(bus.out_valid), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    clear_tb();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mon_en = 1'b1;
    add_pkt(3, 1, 1'b1);
    add_pkt(0, 1, 1'b1);
    run_phase("after_midrst", 50);
    check("midrst_len", 64'(seq.size()), 64'd2);
    if (seq.size() == 2) begin
      check("midrst_first_ch", 64'(seq[0]), 64'd0);
      check("midrst_second_ch", 64'(seq[1]), 64'd3);
    end

    // Randomised traffic on all inputs with random valid and ready
    do_reset();
    vpct = 60; rpct = 70;
    for (int p = 0; p < 60; p++) add_pkt($urandom_range(NUM_IN - 1), $urandom_range(5, 1), ($urandom_range(9) != 0));
    run_phase("random", 5000);
    vpct = 100; rpct = 100;

    // Fixed priority: inputs 1 and 2 always valid, only channel 1 may pass
    do_reset();
    b1 = 0;
    acc1 = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      bp.in_valid = 4'b0110;
      bp.in_startofpacket = {1'b0, 1'b1, (b1 == 0), 1'b0};
      bp.in_endofpacket = {1'b0, 1'b0, (b1 == 2), 1'b0};
      bp.in_data = $urandom;
      bp.out_ready = 1'b1;
      #1;
      check("prio_in_ready2", 64'(bp.in_ready[2]), 64'd0);
      if (bp.in_ready[1]) begin
        acc1++;
        b1 = (b1 + 1) % 3;
      end
      if (bp.out_valid) check("prio_out_channel", 64'(bp.out_channel), 64'd1);
    end
    bp.in_valid = '0;
    check("prio_progress", 64'(acc1 > 20), 64'd1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
